uart_reg_hub: RTL

Parametrised UART-driven register bank that replaces the fixed four-byte shift display and single key-to-UART counter in the board top level. It sits between the `uart_hs` byte interface, a push key, and display/VGA consumers. It takes received bytes either as a legacy shift stream or as addressed register writes (escape protocol with timeout), debounces the key, and arbitrates key-counter bytes and write acknowledgements onto the UART transmitter.

---
 rtl/uart_reg_hub.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_reg_hub.sv
// uart_reg_hub: a register bank driven by UART bytes. Bytes arrive either as a
// plain shift stream or as escaped, addressed writes that time out when the
// line goes idle. A debounced push key and write acknowledgements share the
// UART transmitter.
//
// Handshakes: rx_valid is a one-cycle strobe, and rx_data is sampled only in
// that cycle. There is no back-pressure on receive. tx_send is a one-cycle
// strobe that is only issued when tx_busy was low at the deciding edge. A
// 2-cycle guard follows each send so the transmitter has time to raise busy.
// tx_data holds its value from one send until the next.
module uart_reg_hub #(
  parameter int         NUM_REGS = 4,
  parameter int         DEBOUNCE = 1000000,
  parameter int         TIMEOUT  = 5000000,
  parameter logic [7:0] TX_INIT  = 8'h30,
  parameter logic [7:0] ESC      = 8'hA5
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_send,
  output logic [7:0]            tx_data,
  input  logic                  key_n,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  vga_mode,
  output logic [7:0]            err_cnt,
  output logic [1:0]            dbg_state  // parser state: 0 IDLE, 1 ADDR, 2 DATA
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      regs_q [NUM_REGS];
  logic [7:0]      regs_d [NUM_REGS];
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      err_q, err_d;
  logic            err_inc, ack_set;

  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic            deb_lvl_q, deb_lvl_d, key_fall_q, key_fall_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;

  logic            ack_pend_q, ack_pend_d, key_pend_q, key_pend_d;
  logic [7:0]      ack_byte_q, ack_byte_d, key_cnt_q, key_cnt_d;
  logic [1:0]      guard_q, guard_d;
  logic            tx_send_q, tx_send_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            send_ack, send_key;

  // Byte parser: shift stream, escape/address/data decode and idle timeout
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    tmo_d   = tmo_q;
    err_inc = 1'b0;
    ack_set = 1'b0;
    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == ESC) begin
            state_d = ST_ADDR;
          end else begin
            for (int i = 1; i < NUM_REGS; i++) regs_d[i] = regs_q[i-1];
            regs_d[0] = rx_data;
          end
        end
        ST_ADDR: begin
          if (rx_data == ESC) begin
            // Doubled escape is a literal escape byte in the stream
            for (int i = 1; i < NUM_REGS; i++) regs_d[i] = regs_q[i-1];
            regs_d[0] = ESC;
            state_d   = ST_IDLE;
          end else if ({1'b0, rx_data[3:0]} < 5'(NUM_REGS)) begin
            idx_d   = rx_data[3:0];
            state_d = ST_DATA;
          end else begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == 4'(i)) regs_d[i] = rx_data;
          end
          ack_set = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A byte arriving on the expiry cycle takes the branch above instead
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        tmo_d   = '0;
        err_inc = 1'b1;
        state_d = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // Key synchroniser and debouncer; a debounced fall produces a one-cycle pulse
  always_comb begin
    sync1_d    = key_n;
    sync2_d    = sync1_q;
    deb_lvl_d  = deb_lvl_q;
    deb_cnt_d  = deb_cnt_q;
    key_fall_d = 1'b0;
    if (sync2_q == deb_lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
      deb_lvl_d  = sync2_q;
      deb_cnt_d  = '0;
      key_fall_d = ~sync2_q;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Transmit arbiter: ack beats key, with a guard after every send
  always_comb begin
    send_ack   = ack_pend_q && !tx_busy && (guard_q == 2'd0);
    send_key   = key_pend_q && !ack_pend_q && !tx_busy && (guard_q == 2'd0);
    tx_send_d  = send_ack || send_key;
    tx_data_d  = tx_data_q;
    key_cnt_d  = key_cnt_q;
    if (send_ack) begin
      tx_data_d = ack_byte_q;
    end else if (send_key) begin
      tx_data_d = key_cnt_q;
      key_cnt_d = key_cnt_q + 8'd1;
    end
    if (tx_send_d)            guard_d = 2'd2;
    else if (guard_q != 2'd0) guard_d = guard_q - 2'd1;
    else                      guard_d = 2'd0;
    // A new event in the same cycle as its own send keeps the flag set
    ack_pend_d = ack_set ? 1'b1 : (send_ack ? 1'b0 : ack_pend_q);
    ack_byte_d = ack_set ? (8'h80 | {4'b0, idx_q}) : ack_byte_q;
    key_pend_d = key_fall_q ? 1'b1 : (send_key ? 1'b0 : key_pend_q);
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_lvl_q  <= 1'b1;
      deb_cnt_q  <= '0;
      key_fall_q <= 1'b0;
      ack_pend_q <= 1'b0;
      ack_byte_q <= '0;
      key_pend_q <= 1'b0;
      key_cnt_q  <= TX_INIT;
      guard_q    <= '0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      regs_q     <= regs_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_cnt_q  <= deb_cnt_d;
      key_fall_q <= key_fall_d;
      ack_pend_q <= ack_pend_d;
      ack_byte_q <= ack_byte_d;
      key_pend_q <= key_pend_d;
      key_cnt_q  <= key_cnt_d;
      guard_q    <= guard_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Flatten the register array onto the output bus
  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[8*i +: 8] = regs_q[i];
  end

  assign vga_mode  = regs_q[0][0];
  assign err_cnt   = err_q;
  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;
  assign dbg_state = state_q;

endmodule
